// File: rtl/jedro_1_alu_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : jedro_1_alu_unit_if
//  Brief    : Operand/result bundle between decoder, ALU and register file.
//  Revision : 1.0
// ============================================================================
interface jedro_1_alu_unit_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_OP_WIDTH   = 4,
  parameter int REG_ADDR_WIDTH = 5
);
  logic [ALU_OP_WIDTH-1:0]   alu_op_sel_i;
  logic [DATA_WIDTH-1:0]     opa_i;
  logic [DATA_WIDTH-1:0]     opb_i;
  logic [REG_ADDR_WIDTH-1:0] reg_alu_dest_addr_i;
  logic                      alu_reg_wb_i;
  logic [DATA_WIDTH-1:0]     res_o;
  logic                      overflow_o;
  logic [REG_ADDR_WIDTH-1:0] reg_alu_dest_addr_o;
  logic                      alu_reg_wb_o;

  modport master (
    output alu_op_sel_i, opa_i, opb_i, reg_alu_dest_addr_i, alu_reg_wb_i,
    input  res_o, overflow_o, reg_alu_dest_addr_o, alu_reg_wb_o
  );

  modport slave (
    input  alu_op_sel_i, opa_i, opb_i, reg_alu_dest_addr_i, alu_reg_wb_i,
    output res_o, overflow_o, reg_alu_dest_addr_o, alu_reg_wb_o
  );
endinterface
`default_nettype wire

// File: rtl/jedro_1_alu_unit.sv
`default_nettype none
// ============================================================================
//  Module   : jedro_1_alu_unit
//  Brief    : Single-stage registered RV32I integer ALU with writeback forwarding.
//  Revision : 1.0
// ============================================================================
module jedro_1_alu_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_OP_WIDTH   = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  wire logic clk_i,
  input  wire logic rstn_i,
  jedro_1_alu_unit_if.slave alu_if
);
  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

  // Encoding is {funct7[5], funct3}
  localparam logic [ALU_OP_WIDTH-1:0] c_OP_ADD  = 4'b0000;
  localparam logic [ALU_OP_WIDTH-1:0] c_OP_SUB  = 4'b1000;
  localparam logic [ALU_OP_WIDTH-1:0] c_OP_SLL  = 4'b0001;
  localparam logic [ALU_OP_WIDTH-1:0] c_OP_SLT  = 4'b0010;
  localparam logic [ALU_OP_WIDTH-1:0] c_OP_SLTU = 4'b0011;
  localparam logic [ALU_OP_WIDTH-1:0] c_OP_XOR  = 4'b0100;
  localparam logic [ALU_OP_WIDTH-1:0] c_OP_SRL  = 4'b0101;
  localparam logic [ALU_OP_WIDTH-1:0] c_OP_SRA  = 4'b1101;
  localparam logic [ALU_OP_WIDTH-1:0] c_OP_OR   = 4'b0110;
  localparam logic [ALU_OP_WIDTH-1:0] c_OP_AND  = 4'b0111;

  logic [DATA_WIDTH-1:0]     w_sum;
  logic [DATA_WIDTH-1:0]     w_diff;
  logic [SHAMT_WIDTH-1:0]    w_shamt;
  logic [DATA_WIDTH-1:0]     w_res;
  logic                      w_ovf;

  logic [DATA_WIDTH-1:0]     r_res;
  logic                      r_ovf;
  logic [REG_ADDR_WIDTH-1:0] r_dest;
  logic                      r_wb;

  assign w_sum   = alu_if.opa_i + alu_if.opb_i;
  assign w_diff  = alu_if.opa_i - alu_if.opb_i;
  assign w_shamt = alu_if.opb_i[SHAMT_WIDTH-1:0];

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    unique case (alu_if.alu_op_sel_i)
      c_OP_ADD: begin
        w_res = w_sum;
        // Like-signed operands producing an opposite-signed sum
        w_ovf = (alu_if.opa_i[DATA_WIDTH-1] == alu_if.opb_i[DATA_WIDTH-1]) &&
                (w_sum[DATA_WIDTH-1] != alu_if.opa_i[DATA_WIDTH-1]);
      end
      c_OP_SUB: begin
        w_res = w_diff;
        w_ovf = (alu_if.opa_i[DATA_WIDTH-1] != alu_if.opb_i[DATA_WIDTH-1]) &&
                (w_diff[DATA_WIDTH-1] != alu_if.opa_i[DATA_WIDTH-1]);
      end
      c_OP_SLL:  w_res = alu_if.opa_i << w_shamt;
      c_OP_SLT:  w_res = {{(DATA_WIDTH-1){1'b0}},
                          ($signed(alu_if.opa_i) < $signed(alu_if.opb_i))};
      c_OP_SLTU: w_res = {{(DATA_WIDTH-1){1'b0}}, (alu_if.opa_i < alu_if.opb_i)};
      c_OP_XOR:  w_res = alu_if.opa_i ^ alu_if.opb_i;
      c_OP_SRL:  w_res = alu_if.opa_i >> w_shamt;
      c_OP_SRA:  w_res = $unsigned($signed(alu_if.opa_i) >>> w_shamt);
      c_OP_OR:   w_res = alu_if.opa_i | alu_if.opb_i;
      c_OP_AND:  w_res = alu_if.opa_i & alu_if.opb_i;
      default: begin
        w_res = '0;
        w_ovf = 1'b0;
      end
    endcase
  end

  // rstn_i is active-high despite its name
  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      r_res  <= '0;
      r_ovf  <= 1'b0;
      r_dest <= '0;
      r_wb   <= 1'b0;
    end else begin
      r_res  <= w_res;
      r_ovf  <= w_ovf;
      r_dest <= alu_if.reg_alu_dest_addr_i;
      r_wb   <= alu_if.alu_reg_wb_i;
    end
  end

  assign alu_if.res_o               = r_res;
  assign alu_if.overflow_o          = r_ovf;
  assign alu_if.reg_alu_dest_addr_o = r_dest;
  assign alu_if.alu_reg_wb_o        = r_wb;
endmodule
`default_nettype wire

// File: tb/tb_jedro_1_alu_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jedro_1_alu_unit
//  Brief    : Scoreboard bench for the registered RV32I ALU.
//  Revision : 1.0
// ============================================================================
module tb_jedro_1_alu_unit;
  logic clk_i  = 1'b0;
  logic rstn_i = 1'b1;

  jedro_1_alu_unit_if #(.DATA_WIDTH(32), .ALU_OP_WIDTH(4), .REG_ADDR_WIDTH(5)) alu_if ();

  jedro_1_alu_unit #(.DATA_WIDTH(32), .ALU_OP_WIDTH(4), .REG_ADDR_WIDTH(5)) u_dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .alu_if (alu_if)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        ovf;
    logic [4:0]  dest;
    logic        wb;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model built from wide signed arithmetic and explicit masks
  function automatic exp_t model(input string tag, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] dest, input logic wb,
                                 input logic rst);
    exp_t   e;
    longint sa, sb, r;
    int     sh;
    e.tag = tag; e.res = '0; e.ovf = 1'b0; e.dest = '0; e.wb = 1'b0;
    if (rst) return e;
    e.dest = dest; e.wb = wb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    case (op)
      4'b0000: begin r = sa + sb; e.res = r[31:0]; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'b1000: begin r = sa - sb; e.res = r[31:0]; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'b0001: e.res = a << sh;
      4'b0010: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'b0011: e.res = ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
      4'b0100: e.res = a ^ b;
      4'b0101: e.res = a >> sh;
      4'b1101: e.res = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'b0110: e.res = a | b;
      4'b0111: e.res = a & b;
      default: e.res = '0;
    endcase
    return e;
  endfunction

  // Drive one operation, push its expectation, then pop and compare one cycle later
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] dest, input logic wb,
                       input logic rst);
    exp_t e;
    rstn_i                     = rst;
    alu_if.alu_op_sel_i        = op;
    alu_if.opa_i               = a;
    alu_if.opb_i               = b;
    alu_if.reg_alu_dest_addr_i = dest;
    alu_if.alu_reg_wb_i        = wb;
    exp_q.push_back(model(tag, op, a, b, dest, wb, rst));
    @(posedge clk_i);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({e.tag, ".res"},  alu_if.res_o, e.res);
      check({e.tag, ".ovf"},  {31'd0, alu_if.overflow_o}, {31'd0, e.ovf});
      check({e.tag, ".dest"}, {27'd0, alu_if.reg_alu_dest_addr_o}, {27'd0, e.dest});
      check({e.tag, ".wb"},   {31'd0, alu_if.alu_reg_wb_o}, {31'd0, e.wb});
    end
  endtask

  initial begin
    logic [3:0] undef_ops [6] = '{4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1110, 4'b1111};

    issue("rst0", 4'b0000, 32'h1234_5678, 32'h1111_1111, 5'd7, 1'b1, 1'b1);
    issue("rst1", 4'b1000, 32'h8000_0000, 32'h0000_0001, 5'd9, 1'b1, 1'b1);

    issue("add_ovf",  4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd5, 1'b1, 1'b0);
    issue("sub_neg",  4'b1000, 32'h0000_0003, 32'h0000_0005, 5'd6, 1'b1, 1'b0);
    issue("sub_ovf",  4'b1000, 32'h8000_0000, 32'h0000_0001, 5'd4, 1'b1, 1'b0);
    issue("add_novf", 4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0, 1'b0);
    issue("slt",      4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd8, 1'b1, 1'b0);
    issue("sltu",     4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 5'd8, 1'b1, 1'b0);
    issue("slt_eq",   4'b0010, 32'h8000_0000, 32'h8000_0000, 5'd8, 1'b1, 1'b0);
    issue("sra4",     4'b1101, 32'h8000_0010, 32'h0000_0004, 5'd10, 1'b1, 1'b0);
    issue("srl4",     4'b0101, 32'h8000_0010, 32'h0000_0004, 5'd11, 1'b1, 1'b0);
    issue("sll24",    4'b0001, 32'h8000_0010, 32'h0000_0024, 5'd12, 1'b1, 1'b0);
    issue("sra0",     4'b1101, 32'h8000_0010, 32'h0000_0000, 5'd13, 1'b1, 1'b0);
    issue("sra31",    4'b1101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1, 1'b0);
    issue("and",      4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd14, 1'b1, 1'b0);
    issue("or",       4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd15, 1'b1, 1'b0);
    issue("xor",      4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd16, 1'b1, 1'b0);
    foreach (undef_ops[i])
      issue($sformatf("undef%0d", i), undef_ops[i], 32'h7FFF_FFFF, 32'h0000_0001, 5'd17 + 5'(i), 1'b1, 1'b0);

    issue("b2b_add", 4'b0000, 32'd1,  32'd2, 5'd1, 1'b1, 1'b0);
    issue("b2b_sub", 4'b1000, 32'd10, 32'd4, 5'd2, 1'b1, 1'b0);
    issue("b2b_and", 4'b0111, 32'd6,  32'd3, 5'd3, 1'b1, 1'b0);
    issue("b2b_add", 4'b0000, 32'd1,  32'd2, 5'd1, 1'b1, 1'b0);
    issue("b2b_sub", 4'b1000, 32'd10, 32'd4, 5'd2, 1'b1, 1'b0);
    issue("b2b_rst", 4'b0111, 32'd6,  32'd3, 5'd3, 1'b1, 1'b1);

    for (int i = 0; i < 60; i++)
      issue($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), $urandom, $urandom,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/jedro_1_alu_unit.md
Name: jedro_1_alu_unit

Overview:
- Single-stage registered integer ALU for the jedro_1 RV32I core. It sits between the register-file read ports and the register-file write port.
- It computes the RV32I register/immediate arithmetic, logic, shift and compare operations selected by the decoder.
- It forwards the writeback destination address and write-enable alongside the result, so the result and its writeback control appear at the outputs in the same cycle.

Parameters:
- DATA_WIDTH, 32, operand/result width (only 32 supported).
- ALU_OP_WIDTH, 4, width of the operation select.
- REG_ADDR_WIDTH, 5, width of a register address.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rstn_i  in  1  reset, synchronous and active-high: 1 = reset. The port keeps the codebase name despite its active-high polarity.
- alu_op_sel_i  in  ALU_OP_WIDTH  operation select.
- opa_i  in  DATA_WIDTH  operand A (rs1 data).
- opb_i  in  DATA_WIDTH  operand B (rs2 data or sign-extended immediate, muxed outside).
- res_o  out  DATA_WIDTH  registered result.
- overflow_o  out  1  registered signed-overflow flag.
- reg_alu_dest_addr_i  in  REG_ADDR_WIDTH  destination register of this operation.
- reg_alu_dest_addr_o  out  REG_ADDR_WIDTH  destination register aligned with res_o.
- alu_reg_wb_i  in  1  operation must be written back.
- alu_reg_wb_o  out  1  write-enable aligned with res_o, drives the regfile write port.

Behaviour:
- All outputs are registered, with latency exactly 1 cycle. There is no stall or handshake: a new operation is accepted every cycle.
- Inputs sampled at edge N appear on the outputs after edge N; outputs hold until the next edge.
- Reset: on a rising edge with rstn_i=1, res_o=0, overflow_o=0, reg_alu_dest_addr_o=0 and alu_reg_wb_o=0. Inputs are ignored during that cycle.
- Reset asserted mid-stream discards the in-flight result. No writeback may be signalled in the cycle after a reset edge.
- Operation encoding is {funct7[5], funct3}:
  - 0000 ADD: opa+opb, modulo 2^32.
  - 1000 SUB: opa-opb, modulo 2^32.
  - 0001 SLL: opa << opb[4:0].
  - 0010 SLT: 1 if signed(opa)<signed(opb), else 0.
  - 0011 SLTU: 1 if unsigned(opa)<unsigned(opb), else 0.
  - 0100 XOR.
  - 0101 SRL: logical right shift by opb[4:0].
  - 1101 SRA: arithmetic right shift by opb[4:0], replicating opa[31].
  - 0110 OR.
  - 0111 AND.
- Undefined codes (1001, 1010, 1011, 1100, 1110, 1111) give res_o=0 and overflow_o=0. The passthrough outputs reg_alu_dest_addr_o and alu_reg_wb_o still forward their inputs.
- Shift rules:
  - Only opb[4:0] is used; opb[31:5] is ignored.
  - A shift by 0 returns opa unchanged.
- Overflow rules:
  - ADD: overflow_o=1 when both operands have the same sign and the result sign differs.
  - SUB: overflow_o=1 when the operand signs differ and the result sign differs from opa.
  - All other operations: overflow_o=0.
  - overflow_o is informational only and does not suppress writeback.
- reg_alu_dest_addr_o and alu_reg_wb_o are 1-cycle delayed copies of their inputs, independent of the operation.
- The block does not special-case destination x0; the register file ignores writes to x0.
- The datapath is purely combinational ahead of a single output register: no multi-cycle operations and no internal state beyond the output registers.

Test Plan:
- Reset: hold rstn_i=1 for 2 cycles with arbitrary inputs -> res_o=0, overflow_o=0, reg_alu_dest_addr_o=0, alu_reg_wb_o=0.
- Add/sub with overflow:
  - ADD opa=0x7FFFFFFF, opb=1, dest=5, wb=1 -> next cycle res_o=0x80000000, overflow_o=1, reg_alu_dest_addr_o=5, alu_reg_wb_o=1.
  - SUB opa=3, opb=5 -> res_o=0xFFFFFFFE, overflow_o=0.
- Compares:
  - SLT opa=0xFFFFFFFF (-1), opb=1 -> res_o=1.
  - SLTU with the same operands -> res_o=0.
- Shifts with opa=0x80000010:
  - SRA opb=4 -> 0xF8000001.
  - SRL opb=4 -> 0x08000001.
  - SLL opb=0x24 (amount 4) -> 0x00000100.
  - SRA opb=0 -> 0x80000010.
- Logic with opa=0xF0F0F0F0, opb=0x0FF00FF0:
  - AND -> 0x00F000F0.
  - OR -> 0xFFF0FFF0.
  - XOR -> 0xFF00FF00.
  - Undefined code 1111 -> res_o=0, with dest and wb still forwarded.
- Back-to-back pipelining:
  - Issue ADD 1+2 (dest 1), SUB 10-4 (dest 2), AND 6&3 (dest 3) on consecutive cycles -> res_o sequence 3, 6, 2 with dest 1, 2, 3 each one cycle later.
  - Assert reset on the third cycle -> outputs 0 and alu_reg_wb_o=0 instead of 2.
